// File: rtl/pll_mon_pkg.sv
// Shared types and helpers for the PLL lock monitor: FSM encoding and width functions.
package pll_mon_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    LOCKED    = 3'd3,
    SUSPEND   = 3'd4,
    FAILED    = 3'd5
  } pll_state_t;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single-bit asynchronous input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_lock_monitor.sv
// Supervises PLL lock from the free-running input clock: drives PLL reset,
// retries on timeout or lock loss, and flags a sticky failure after MAX_RETRY attempts.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3,
  localparam int CNT_RAW      = clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)),
  localparam int CNT_W        = (CNT_RAW > 0) ? CNT_RAW : 1,
  localparam int RETRY_W      = clog2(MAX_RETRY + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               locked_i,
  input  logic               suspend_i,
  output logic               pll_rst_o,
  output logic               lock_ok_o,
  output logic               lock_lost_o,
  output logic               lock_fail_o,
  output logic [RETRY_W-1:0] retry_cnt_o,
  output logic [2:0]         state_o
);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT      = {CNT_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRY - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

  pll_state_t         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_inc;
  logic [RETRY_W-1:0] retry_reg;
  logic               pll_rst_reg;
  logic               lock_ok_reg;
  logic               lock_lost_reg;
  logic               lock_fail_reg;
  logic               locked_s;
  logic               fail_now;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked_i),
    .q   (locked_s)
  );

  // Counter holds at all-ones instead of wrapping
  assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + 1'b1;

  // Every condition that consumes one attempt; suspend wins over a lock drop in LOCKED
  always_comb begin
    fail_now = 1'b0;
    case (state_reg)
      WAIT_LOCK: fail_now = !locked_s && (cnt_reg == TIMEOUT_LAST);
      STABLE:    fail_now = !locked_s;
      LOCKED:    fail_now = !locked_s && !suspend_i;
      default:   fail_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RESET_PLL;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      pll_rst_reg   <= 1'b1;
      lock_ok_reg   <= 1'b0;
      lock_lost_reg <= 1'b0;
      lock_fail_reg <= 1'b0;
    end else begin
      lock_lost_reg <= 1'b0;
      if (fail_now) begin
        pll_rst_reg   <= 1'b1;
        lock_ok_reg   <= 1'b0;
        cnt_reg       <= '0;
        lock_lost_reg <= (state_reg == LOCKED);
        if (retry_reg == RETRY_LAST) begin
          state_reg     <= FAILED;
          retry_reg     <= RETRY_MAX;
          lock_fail_reg <= 1'b1;
        end else begin
          state_reg <= RESET_PLL;
          retry_reg <= retry_reg + 1'b1;
        end
      end else begin
        case (state_reg)
          RESET_PLL: begin
            if (cnt_reg == RST_LAST) begin
              state_reg   <= WAIT_LOCK;
              cnt_reg     <= '0;
              pll_rst_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
          WAIT_LOCK: begin
            if (locked_s) begin
              state_reg <= STABLE;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
          STABLE: begin
            if (cnt_reg == STABLE_LAST) begin
              state_reg   <= LOCKED;
              retry_reg   <= '0;
              lock_ok_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
          LOCKED: begin
            if (suspend_i) state_reg <= SUSPEND;
          end
          SUSPEND: begin
            if (!suspend_i) begin
              state_reg   <= WAIT_LOCK;
              cnt_reg     <= '0;
              lock_ok_reg <= 1'b0;
            end
          end
          FAILED: begin
          end
          default: begin
            state_reg   <= RESET_PLL;
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b1;
            lock_ok_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pll_rst_o   = pll_rst_reg;
  assign lock_ok_o   = lock_ok_reg;
  assign lock_lost_o = lock_lost_reg;
  assign lock_fail_o = lock_fail_reg;
  assign retry_cnt_o = retry_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor; expectations are queued per cycle and checked as the cycle arrives.
module tb_pll_lock_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked_i = 1'b0;
  logic       suspend_i = 1'b0;
  logic       pll_rst_o;
  logic       lock_ok_o;
  logic       lock_lost_o;
  logic       lock_fail_o;
  logic [1:0] retry_cnt_o;
  logic [2:0] state_o;
  logic [8:0] obs;

  typedef struct {
    int         cyc;
    string      tag;
    logic [8:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   lost_seen, pll_seen, ok_low_seen;

  pll_lock_monitor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .locked_i    (locked_i),
    .suspend_i   (suspend_i),
    .pll_rst_o   (pll_rst_o),
    .lock_ok_o   (lock_ok_o),
    .lock_lost_o (lock_lost_o),
    .lock_fail_o (lock_fail_o),
    .retry_cnt_o (retry_cnt_o),
    .state_o     (state_o)
  );

  always #10 clk = ~clk;

  assign obs = {pll_rst_o, lock_ok_o, lock_lost_o, lock_fail_o, retry_cnt_o, state_o};

  // Packs {pll_rst, lock_ok, lock_lost, lock_fail, retry_cnt, state}
  function automatic logic [8:0] ev(bit pll, bit ok, bit lost, bit fail, int retry, int st);
    return {pll, ok, lost, fail, 2'(retry), 3'(st)};
  endfunction

  task automatic push_exp(int c, string tag, logic [8:0] v);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_due();
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      assert (e.cyc == cyc && obs === e.val) else begin
        n_fail++;
        $error("FAIL %s cyc=%0d (due %0d) observed=%b expected=%b", e.tag, cyc, e.cyc, obs, e.val);
      end
    end
  endtask

  task automatic check_flag(string tag, bit got, bit want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    lost_seen   |= lock_lost_o;
    pll_seen    |= pll_rst_o;
    ok_low_seen |= !lock_ok_o;
    check_due();
  endtask

  task automatic run_to(int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    push_exp(0, "reset_vals", ev(1, 0, 0, 0, 0, 0));
    check_due();
  endtask

  initial begin
    @(negedge clk);

    // Power-up lock, then unexpected loss and relock
    do_reset();
    push_exp(3, "pu_rst_hi", ev(1, 0, 0, 0, 0, 0));
    push_exp(4, "pu_rst_lo", ev(0, 0, 0, 0, 0, 1));
    run_to(9);
    locked_i = 1'b1;
    push_exp(12, "pu_stable", ev(0, 0, 0, 0, 0, 2));
    push_exp(19, "pu_not_ok", ev(0, 0, 0, 0, 0, 2));
    push_exp(20, "pu_lock_ok", ev(0, 1, 0, 0, 0, 3));
    run_to(29);
    locked_i = 1'b0;
    push_exp(31, "loss_still_ok", ev(0, 1, 0, 0, 0, 3));
    push_exp(32, "loss_pulse", ev(1, 0, 1, 0, 1, 0));
    push_exp(33, "loss_pulse_end", ev(1, 0, 0, 0, 1, 0));
    push_exp(35, "loss_rst_last", ev(1, 0, 0, 0, 1, 0));
    push_exp(36, "loss_wait", ev(0, 0, 0, 0, 1, 1));
    run_to(39);
    locked_i = 1'b1;
    push_exp(49, "relock_stable", ev(0, 0, 0, 0, 1, 2));
    push_exp(50, "relock_ok", ev(0, 1, 0, 0, 0, 3));
    run_to(50);

    // Lock glitch while in STABLE
    locked_i = 1'b0;
    do_reset();
    run_to(9);
    locked_i = 1'b1;
    run_to(13);
    locked_i = 1'b0;
    push_exp(15, "gl_stable", ev(0, 0, 0, 0, 0, 2));
    push_exp(16, "gl_retry", ev(1, 0, 0, 0, 1, 0));
    run_to(16);
    locked_i = 1'b1;
    push_exp(19, "gl_rst_hi", ev(1, 0, 0, 0, 1, 0));
    push_exp(20, "gl_wait", ev(0, 0, 0, 0, 1, 1));
    push_exp(21, "gl_stable2", ev(0, 0, 0, 0, 1, 2));
    push_exp(28, "gl_not_ok", ev(0, 0, 0, 0, 1, 2));
    push_exp(29, "gl_lock_ok", ev(0, 1, 0, 0, 0, 3));
    run_to(29);

    // Suspend masks lock loss; release starts a fresh timeout
    locked_i = 1'b0;
    do_reset();
    run_to(9);
    locked_i = 1'b1;
    push_exp(20, "sus_locked", ev(0, 1, 0, 0, 0, 3));
    run_to(24);
    suspend_i = 1'b1;
    push_exp(25, "sus_enter", ev(0, 1, 0, 0, 0, 4));
    run_to(25);
    locked_i = 1'b0;
    lost_seen = 1'b0;
    pll_seen = 1'b0;
    ok_low_seen = 1'b0;
    push_exp(79, "sus_hold", ev(0, 1, 0, 0, 0, 4));
    run_to(79);
    check_flag("sus_no_lost", lost_seen, 1'b0);
    check_flag("sus_no_pllrst", pll_seen, 1'b0);
    check_flag("sus_ok_held", ok_low_seen, 1'b0);
    suspend_i = 1'b0;
    push_exp(80, "sus_exit", ev(0, 0, 0, 0, 0, 1));
    push_exp(111, "sus_wait_last", ev(0, 0, 0, 0, 0, 1));
    push_exp(112, "sus_timeout", ev(1, 0, 0, 0, 1, 0));
    run_to(112);

    // Repeated timeout into FAILED, then reset during FAILED and mid-pulse
    do_reset();
    push_exp(35, "to_wait_last", ev(0, 0, 0, 0, 0, 1));
    push_exp(36, "to_retry1", ev(1, 0, 0, 0, 1, 0));
    push_exp(40, "to_wait2", ev(0, 0, 0, 0, 1, 1));
    push_exp(71, "to_wait2_last", ev(0, 0, 0, 0, 1, 1));
    push_exp(72, "to_failed", ev(1, 0, 0, 1, 2, 5));
    run_to(100);
    locked_i = 1'b1;
    push_exp(180, "to_failed_held", ev(1, 0, 0, 1, 2, 5));
    run_to(180);
    locked_i = 1'b0;
    do_reset();
    run_to(2);
    do_reset();
    push_exp(3, "mid_rst_hi", ev(1, 0, 0, 0, 0, 0));
    push_exp(4, "mid_rst_lo", ev(0, 0, 0, 0, 0, 1));
    run_to(4);

    check_flag("sb_drained", sb.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
